// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC and the IF/ID register,
// handles stall, redirect and halt-opcode fetch stop.
module imem_fetch_ctrl #(
    parameter logic [5:0]  HALT_OP = 6'b111111,
    parameter logic [31:0] BUBBLE  = 32'hFC000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_instr,
    output logic [31:0] imem_addr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam logic [31:0] INIT_PC = 32'hFFFFFFFC;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic [15:0] cnt_q, cnt_d;

    logic [31:0] pc_plus4;
    logic [31:0] redir_aligned;
    logic        is_halt;
    logic        unused_ok;

    assign pc_plus4      = pc_q + 32'd4;
    assign redir_aligned = {redirect_pc[31:2], 2'b00};
    assign is_halt       = (imem_instr[31:26] == HALT_OP);
    assign unused_ok     = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INIT;
            pc_q     <= INIT_PC;
            instr_q  <= BUBBLE;
            pc4_q    <= 32'd0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc4_q    <= pc4_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                state_d = RUN;
                pc_d    = 32'd0;
                instr_d = BUBBLE;
                valid_d = 1'b0;
            end
            RUN: begin
                if (redirect) begin
                    pc_d    = redir_aligned;
                    instr_d = BUBBLE;
                    valid_d = 1'b0;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (is_halt) begin
                    state_d = HALTED;
                    instr_d = BUBBLE;
                    valid_d = 1'b0;
                end else begin
                    pc_d    = pc_plus4;
                    pc4_d   = pc_plus4;
                    instr_d = imem_instr;
                    valid_d = 1'b1;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            HALTED: begin
                // An older branch still in flight can cancel the halt
                instr_d = BUBBLE;
                valid_d = 1'b0;
                if (redirect) begin
                    state_d = RUN;
                    pc_d    = redir_aligned;
                end
            end
            default: begin
                state_d = INIT;
                pc_d    = INIT_PC;
                instr_d = BUBBLE;
                valid_d = 1'b0;
            end
        endcase
        halted_d = (state_d == HALTED);
    end

    assign imem_addr   = pc_q;
    assign ifid_instr  = instr_q;
    assign ifid_pc4    = pc4_q;
    assign ifid_valid  = valid_q;
    assign halted      = halted_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl with a small
// combinational instruction memory model.
module tb_imem_fetch_ctrl;

    localparam logic [31:0] BUB = 32'hFC000000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_instr;
    logic [31:0] imem_addr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] mem [0:63];

    int n_chk;
    int n_fail;

    imem_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_instr  (imem_instr),
        .imem_addr   (imem_addr),
        .ifid_instr  (ifid_instr),
        .ifid_pc4    (ifid_pc4),
        .ifid_valid  (ifid_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    assign imem_instr = mem[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int i);
        return 32'h20000000 | 32'(i);
    endfunction

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 64; i++) mem[i] = word(i);
        mem[3]      = BUB;
        rst         = 1'b1;
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h00000080;

        step();
        chk("rst_addr", imem_addr, 32'hFFFFFFFC);
        chk("rst_instr", ifid_instr, BUB);
        chk("rst_pc4", ifid_pc4, 32'd0);
        chk("rst_valid", 32'(ifid_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_cnt", 32'(fetch_count), 32'd0);

        rst = 1'b0;
        step();
        chk("init_addr", imem_addr, 32'd0);
        chk("init_instr", ifid_instr, BUB);
        chk("init_valid", 32'(ifid_valid), 32'd0);
        stall    = 1'b0;
        redirect = 1'b0;

        step();
        chk("f0_addr", imem_addr, 32'd4);
        chk("f0_instr", ifid_instr, word(0));
        chk("f0_pc4", ifid_pc4, 32'd4);
        chk("f0_valid", 32'(ifid_valid), 32'd1);
        step();
        chk("f1_addr", imem_addr, 32'd8);
        chk("f1_instr", ifid_instr, word(1));
        chk("f1_pc4", ifid_pc4, 32'd8);
        chk("f1_cnt", 32'(fetch_count), 32'd2);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stl_addr", imem_addr, 32'd8);
            chk("stl_instr", ifid_instr, word(1));
            chk("stl_pc4", ifid_pc4, 32'd8);
            chk("stl_cnt", 32'(fetch_count), 32'd2);
        end
        stall = 1'b0;
        step();
        chk("res_addr", imem_addr, 32'd12);
        chk("res_instr", ifid_instr, word(2));
        chk("res_cnt", 32'(fetch_count), 32'd3);

        step();
        chk("hlt_halted", 32'(halted), 32'd1);
        chk("hlt_addr", imem_addr, 32'd12);
        chk("hlt_valid", 32'(ifid_valid), 32'd0);
        chk("hlt_instr", ifid_instr, BUB);
        chk("hlt_cnt", 32'(fetch_count), 32'd3);
        stall = 1'b1;
        step();
        chk("hlt2_halted", 32'(halted), 32'd1);
        chk("hlt2_addr", imem_addr, 32'd12);
        stall = 1'b0;
        step();
        chk("hlt3_addr", imem_addr, 32'd12);

        redirect    = 1'b1;
        redirect_pc = 32'h00000020;
        step();
        chk("unh_halted", 32'(halted), 32'd0);
        chk("unh_addr", imem_addr, 32'h20);
        chk("unh_valid", 32'(ifid_valid), 32'd0);
        redirect = 1'b0;
        step();
        chk("unh_f_addr", imem_addr, 32'h24);
        chk("unh_f_instr", ifid_instr, word(8));
        chk("unh_f_cnt", 32'(fetch_count), 32'd4);

        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'h00000043;
        step();
        chk("rs_addr", imem_addr, 32'h40);
        chk("rs_valid", 32'(ifid_valid), 32'd0);
        chk("rs_instr", ifid_instr, BUB);
        chk("rs_cnt", 32'(fetch_count), 32'd4);
        stall = 1'b0;

        redirect_pc = 32'hFFFFFFF8;
        step();
        chk("wr_addr0", imem_addr, 32'hFFFFFFF8);
        redirect = 1'b0;
        step();
        chk("wr_addr1", imem_addr, 32'hFFFFFFFC);
        chk("wr_instr1", ifid_instr, word(62));
        step();
        chk("wr_addr2", imem_addr, 32'd0);
        chk("wr_pc4", ifid_pc4, 32'd0);
        chk("wr_cnt", 32'(fetch_count), 32'd6);

        redirect    = 1'b1;
        redirect_pc = 32'h0000000C;
        step();
        redirect = 1'b0;
        step();
        chk("h2_halted", 32'(halted), 32'd1);
        chk("h2_cnt", 32'(fetch_count), 32'd6);

        rst      = 1'b1;
        redirect = 1'b1;
        stall    = 1'b1;
        step();
        chk("hr_addr", imem_addr, 32'hFFFFFFFC);
        chk("hr_cnt", 32'(fetch_count), 32'd0);
        chk("hr_halted", 32'(halted), 32'd0);
        chk("hr_valid", 32'(ifid_valid), 32'd0);
        rst      = 1'b0;
        redirect = 1'b0;
        stall    = 1'b0;
        step();
        chk("hr_run_addr", imem_addr, 32'd0);
        step();
        chk("hr_f_instr", ifid_instr, word(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
